// File: rtl/cdc_xfer_arbiter.sv
// Round-robin arbiter feeding a toggle-handshake CDC channel: one transfer in
// flight, completion on ack/req level match, optional ack timeout with recovery.
module cdc_xfer_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [WIDTH-1:0]           xfer_data,
    output logic                       xfer_req,
    input  logic                       xfer_ack,
    output logic                       done_valid,
    output logic [$clog2(NUM_REQ)-1:0] done_id,
    output logic                       err_timeout,
    output logic                       busy
);
    localparam int IDW   = $clog2(NUM_REQ);
    localparam int CW    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int LIMIT = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, RECOVER} state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   last_grant_q, last_grant_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   done_id_q, done_id_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] xfer_data_q, xfer_data_d;
    logic             xfer_req_q, xfer_req_d;
    logic             done_valid_q, done_valid_d;
    logic             err_timeout_q, err_timeout_d;

    logic [WIDTH-1:0]   payload [NUM_REQ];
    logic               found;
    logic [IDW-1:0]     cand;
    logic [IDW-1:0]     win;
    logic [NUM_REQ-1:0] grant_oh;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_payload
        assign payload[i] = req_data[i*WIDTH +: WIDTH];
    end

    // Search upward starting one past the previous winner.
    always_comb begin
        found = 1'b0;
        cand  = '0;
        win   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDW'((int'(last_grant_q) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // The done pulse cycle is held off so the next grant lands after it.
    always_comb begin
        grant_oh = '0;
        if (reset_n && state_q == IDLE && !done_valid_q && found) begin
            grant_oh[win] = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        id_d          = id_q;
        done_id_d     = done_id_q;
        cnt_d         = cnt_q;
        xfer_data_d   = xfer_data_q;
        xfer_req_d    = xfer_req_q;
        done_valid_d  = 1'b0;
        err_timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|grant_oh) begin
                    xfer_data_d  = payload[win];
                    xfer_req_d   = ~xfer_req_q;
                    last_grant_d = win;
                    id_d         = win;
                    cnt_d        = '0;
                    state_d      = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // Ack is checked first so it wins a tie with the limit.
                if (xfer_ack == xfer_req_q) begin
                    done_valid_d = 1'b1;
                    done_id_d    = id_q;
                    state_d      = IDLE;
                end else if (TIMEOUT_CYC > 0 && cnt_q == LIMIT_C) begin
                    err_timeout_d = 1'b1;
                    state_d       = RECOVER;
                end else if (TIMEOUT_CYC > 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RECOVER: begin
                if (xfer_ack == xfer_req_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            last_grant_q  <= IDW'(NUM_REQ - 1);
            id_q          <= '0;
            done_id_q     <= '0;
            cnt_q         <= '0;
            xfer_data_q   <= '0;
            xfer_req_q    <= 1'b0;
            done_valid_q  <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            id_q          <= id_d;
            done_id_q     <= done_id_d;
            cnt_q         <= cnt_d;
            xfer_data_q   <= xfer_data_d;
            xfer_req_q    <= xfer_req_d;
            done_valid_q  <= done_valid_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign req_ready   = grant_oh;
    assign xfer_data   = xfer_data_q;
    assign xfer_req    = xfer_req_q;
    assign done_valid  = done_valid_q;
    assign done_id     = done_id_q;
    assign err_timeout = err_timeout_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// Bench for cdc_xfer_arbiter: directed scenarios plus random traffic, checked
// each cycle against a transaction-level reference kept in the bench.
module tb_cdc_xfer_arbiter;
    localparam int N   = 4;
    localparam int W   = 8;
    localparam int TO  = 8;
    localparam int IDW = $clog2(N);

    logic           clk       = 1'b0;
    logic           reset_n   = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data  = '0;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   xfer_data;
    logic           xfer_req;
    logic           xfer_ack  = 1'b0;
    logic           done_valid, err_timeout, busy;
    logic [IDW-1:0] done_id;

    logic [N-1:0]   req_valid_z = '0;
    logic [N*W-1:0] req_data_z  = '0;
    logic [N-1:0]   req_ready_z;
    logic [W-1:0]   xfer_data_z;
    logic           xfer_req_z;
    logic           xfer_ack_z  = 1'b0;
    logic           done_valid_z, err_timeout_z, busy_z;
    logic [IDW-1:0] done_id_z;

    always #5 clk = ~clk;

    cdc_xfer_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT_CYC(TO)) u_dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .xfer_data(xfer_data), .xfer_req(xfer_req),
        .xfer_ack(xfer_ack), .done_valid(done_valid), .done_id(done_id),
        .err_timeout(err_timeout), .busy(busy)
    );

    cdc_xfer_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT_CYC(0)) u_dut_nto (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid_z), .req_data(req_data_z),
        .req_ready(req_ready_z), .xfer_data(xfer_data_z), .xfer_req(xfer_req_z),
        .xfer_ack(xfer_ack_z), .done_valid(done_valid_z), .done_id(done_id_z),
        .err_timeout(err_timeout_z), .busy(busy_z)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: phase 0 = free, 1 = transfer outstanding, 2 = timed out, awaiting late ack
    int         m_phase, m_last, m_id, m_done_id, cyc, grant_cyc, granted;
    bit         m_req, m_done, m_err;
    logic [W-1:0] m_data;

    bit  rand_req, hold_all, rec_order;
    int  ack_fix, ack_wait, ack_dly;
    int  obs_done, obs_err, last_done_id, ready_cyc, err_cyc;
    int  order[$];

    function automatic int rr_pick();
        if (m_phase != 0 || m_done) return -1;
        for (int k = 1; k <= N; k++) begin
            if (req_valid[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_last = N - 1; m_id = 0; m_done_id = 0;
        m_req = 1'b0; m_done = 1'b0; m_err = 1'b0; m_data = '0;
        granted = -1; ack_wait = 0;
    endtask

    task automatic set_ack(input int f);
        ack_fix  = f;
        ack_wait = 0;
        ack_dly  = (f > 0) ? f : int'($urandom_range(1, TO + 3));
    endtask

    task automatic check_outputs();
        logic [N-1:0] er;
        int w;
        er = '0;
        w  = rr_pick();
        if (w >= 0) er[w] = 1'b1;
        chk("req_ready", req_ready, er);
        chk("xfer_req", xfer_req, m_req);
        chk("xfer_data", xfer_data, m_data);
        chk("done_valid", done_valid, m_done);
        chk("done_id", done_id, m_done_id);
        chk("err_timeout", err_timeout, m_err);
        chk("busy", busy, m_phase != 0);
        if (done_valid) begin obs_done++; last_done_id = int'(done_id); end
        if (err_timeout) begin obs_err++; err_cyc = cyc; end
        if (req_ready != '0) ready_cyc = cyc;
        if (rec_order) for (int i = 0; i < N; i++) if (req_ready[i]) order.push_back(i);
    endtask

    task automatic model_step();
        int w;
        w = rr_pick();
        granted = w;
        m_done = 1'b0;
        m_err  = 1'b0;
        cyc++;
        if (m_phase == 0) begin
            if (w >= 0) begin
                m_data = req_data[w*W +: W];
                m_req = ~m_req; m_last = w; m_id = w; grant_cyc = cyc; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (xfer_ack == m_req) begin
                m_done = 1'b1; m_done_id = m_id; m_phase = 0;
            end else if (cyc - grant_cyc == TO) begin
                m_err = 1'b1; m_phase = 2;
            end
        end else if (xfer_ack == m_req) begin
            m_phase = 0;
        end
    endtask

    task automatic drive_next();
        for (int i = 0; i < N; i++) begin
            if (granted == i) begin
                req_data[i*W +: W] = W'($urandom);
                if (hold_all)      req_valid[i] = 1'b1;
                else if (rand_req) req_valid[i] = 1'($urandom_range(0, 1));
                else               req_valid[i] = 1'b0;
            end else if (rand_req && !req_valid[i] && $urandom_range(0, 3) == 0) begin
                req_valid[i] = 1'b1;
                req_data[i*W +: W] = W'($urandom);
            end
        end
        // Channel echo: ack follows req after ack_dly cycles of mismatch.
        if (xfer_req != xfer_ack) begin
            ack_wait++;
            if (ack_wait >= ack_dly) begin
                xfer_ack = xfer_req;
                set_ack(ack_fix);
            end
        end else if (rand_req && m_phase == 0 && $urandom_range(0, 39) == 0) begin
            xfer_ack = ~xfer_ack;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
        drive_next();
    endtask

    task automatic apply_reset(input int hold);
        reset_n  = 1'b0;
        xfer_ack = 1'b0;
        model_reset();
        #1;
        chk("rst_ready", req_ready, '0);
        chk("rst_xfer_req", xfer_req, 1'b0);
        chk("rst_xfer_data", xfer_data, '0);
        chk("rst_done_valid", done_valid, 1'b0);
        chk("rst_done_id", done_id, '0);
        chk("rst_err", err_timeout, 1'b0);
        chk("rst_busy", busy, 1'b0);
        repeat (hold) @(posedge clk);
        #1;
        reset_n = 1'b1;
        obs_done = 0; obs_err = 0; last_done_id = -1;
    endtask

    initial begin
        int errs_z, idle_z;
        cyc = 0; grant_cyc = 0; ready_cyc = 0; err_cyc = 0;
        rand_req = 0; hold_all = 0; rec_order = 0;
        model_reset();
        set_ack(3);
        #2;

        // Single transfer; valid present at release must be granted on the first edge
        req_valid = 4'b0100;
        req_data[2*W +: W] = 8'hA5;
        apply_reset(2);
        repeat (10) cycle();
        chk("t021_done_cnt", obs_done, 1);
        chk("t021_done_id", last_done_id, 2);
        chk("t021_xfer_data", xfer_data, 8'hA5);
        chk("t021_xfer_req", xfer_req, 1'b1);

        // Fairness with all requesters held
        for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
        req_valid = 4'b1111;
        hold_all = 1;
        set_ack(2);
        apply_reset(1);
        order.delete();
        rec_order = 1;
        for (int c = 0; c < 200 && order.size() < 5; c++) cycle();
        rec_order = 0;
        chk("t022_grants", order.size(), 5);
        for (int i = 0; i < order.size() && i < 5; i++) chk("t022_order", order[i], i % N);
        hold_all = 0;

        // Timeout, then a late ack through recovery
        req_valid = 4'b0010;
        req_data[1*W +: W] = W'($urandom);
        set_ack(TO + 5);
        apply_reset(1);
        repeat (25) cycle();
        chk("t023_err_cnt", obs_err, 1);
        chk("t023_done_cnt", obs_done, 0);
        // ready seen in cycle V, grant edge ends V, err visible TO cycles after that edge
        chk("t023_latency", err_cyc - ready_cyc, TO + 1);
        chk("t023_idle", busy, 1'b0);

        // Ack arriving on the limit cycle wins over the timeout
        req_valid = 4'b0001;
        req_data[0 +: W] = W'($urandom);
        set_ack(TO);
        apply_reset(1);
        repeat (14) cycle();
        chk("t024_done_cnt", obs_done, 1);
        chk("t024_err_cnt", obs_err, 0);

        // Ack wiggle while idle must not disturb anything
        xfer_ack = ~xfer_ack;
        repeat (4) cycle();
        chk("t017_done_cnt", obs_done, 1);

        // Random traffic
        rand_req = 1;
        set_ack(0);
        req_valid = 4'($urandom);
        for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
        apply_reset(1);
        repeat (3000) cycle();
        rand_req = 0;

        // Reset while a transfer is outstanding
        req_valid = 4'b0100;
        set_ack(50);
        apply_reset(1);
        repeat (3) cycle();
        chk("t025_busy_pre", busy, 1'b1);
        #2;
        req_valid = 4'b1111;
        hold_all = 1;
        apply_reset(2);
        order.delete();
        rec_order = 1;
        repeat (3) cycle();
        rec_order = 0;
        hold_all = 0;
        chk("t025_first", (order.size() > 0) ? order[0] : -1, 0);

        // Timeout disabled: long ack delay, no error
        req_valid_z = 4'b0010;
        req_data_z[1*W +: W] = 8'h3C;
        @(negedge clk);
        chk("t026_ready", req_ready_z, 4'b0010);
        @(posedge clk);
        #1;
        req_valid_z = '0;
        errs_z = 0;
        idle_z = 0;
        repeat (1000) begin
            @(negedge clk);
            if (err_timeout_z) errs_z++;
            if (!busy_z) idle_z++;
        end
        chk("t026_no_err", errs_z, 0);
        chk("t026_busy", idle_z, 0);
        chk("t026_data", xfer_data_z, 8'h3C);
        @(posedge clk);
        #1;
        xfer_ack_z = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t026_done", done_valid_z, 1'b1);
        chk("t026_done_id", done_id_z, 1);
        chk("t026_err", err_timeout_z, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
